// File: rtl/vt4_vram_pkg.sv
// Shared defaults and types for the VRAM scroll arbiter slice.
package vt4_vram_pkg;

    localparam int unsigned DEF_ROWS  = 30;
    localparam int unsigned DEF_COLS  = 80;
    localparam int unsigned DEF_ROW_W = 5;
    localparam int unsigned DEF_COL_W = 7;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } scroll_state_t;

endpackage

// File: rtl/vram_row_map.sv
// Combinational physical-row mapping: row = (base + offset) mod ROWS.
// Both inputs must already be below ROWS, so one conditional subtract suffices.
module vram_row_map
    import vt4_vram_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned ROW_W = DEF_ROW_W
) (
    input  logic [ROW_W-1:0] base,
    input  logic [ROW_W-1:0] offset,
    output logic [ROW_W-1:0] row
);

    localparam logic [ROW_W:0] ROWS_EXT = (ROW_W + 1)'(ROWS);

    logic [ROW_W:0] sum;

    always_comb begin
        sum = {1'b0, base} + {1'b0, offset};
        if (sum >= ROWS_EXT) begin
            sum = sum - ROWS_EXT;
        end
        row = sum[ROW_W-1:0];
    end

endmodule

// File: rtl/vram_scroll_arbiter.sv
// Owns the VRAM write port and the display top_row pointer; maps logical char
// writes to physical rows and executes scrolls. Optional row clear: VRAM_SCROLL_CLEAR_EN.
module vram_scroll_arbiter
    import vt4_vram_pkg::*;
#(
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned ROW_W = DEF_ROW_W,
    parameter int unsigned COL_W = DEF_COL_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             char_valid,
    output logic             char_ready,
    input  logic [ROW_W-1:0] char_row,
    input  logic [COL_W-1:0] char_col,
    input  logic [7:0]       char_byte,
    input  logic             scroll_valid,
    output logic             scroll_ready,
    output logic             busy,
    output logic [ROW_W-1:0] top_row,
    output logic             write_valid,
    input  logic             write_ready,
    output logic [ROW_W-1:0] write_row,
    output logic [COL_W-1:0] write_col,
    output logic [7:0]       write_byte
);

    localparam logic [ROW_W:0] ROWS_EXT = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0] COLS_EXT = (COL_W + 1)'(COLS);

    logic             slot_free;
    logic [ROW_W-1:0] char_phys_row;
    logic [ROW_W-1:0] top_row_next;

    logic             load_en;
    logic [ROW_W-1:0] load_row;
    logic [COL_W-1:0] load_col;
    logic [7:0]       load_byte;
    logic             top_adv;

    assign slot_free = !write_valid || write_ready;

    vram_row_map #(
        .ROWS (ROWS),
        .ROW_W(ROW_W)
    ) u_char_map (
        .base  (top_row),
        .offset(char_row),
        .row   (char_phys_row)
    );

    vram_row_map #(
        .ROWS (ROWS),
        .ROW_W(ROW_W)
    ) u_top_map (
        .base  (top_row),
        .offset(ROW_W'(1)),
        .row   (top_row_next)
    );

`ifdef VRAM_SCROLL_CLEAR_EN
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    scroll_state_t    state;
    scroll_state_t    state_next;
    logic [ROW_W-1:0] clr_row;
    logic [COL_W-1:0] clr_col;
    logic             clr_start;
    logic             clr_adv;

    always_comb begin
        state_next   = state;
        char_ready   = 1'b0;
        scroll_ready = 1'b0;
        busy         = 1'b0;
        load_en      = 1'b0;
        load_row     = char_phys_row;
        load_col     = char_col;
        load_byte    = char_byte;
        clr_start    = 1'b0;
        clr_adv      = 1'b0;
        top_adv      = 1'b0;
        case (state)
            IDLE: begin
                scroll_ready = slot_free;
                char_ready   = slot_free && !scroll_valid;
                if (scroll_valid && slot_free) begin
                    clr_start  = 1'b1;
                    state_next = CLEAR;
                end else if (char_valid && char_ready) begin
                    load_en = 1'b1;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (slot_free) begin
                    load_en   = 1'b1;
                    load_row  = clr_row;
                    load_col  = clr_col;
                    load_byte = CHAR_SPACE;
                    clr_adv   = 1'b1;
                    // The screen moves only once the last blank is issued.
                    if (clr_col == LAST_COL) begin
                        top_adv    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_row <= '0;
            clr_col <= '0;
        end else begin
            state <= state_next;
            if (clr_start) begin
                clr_row <= top_row;
                clr_col <= '0;
            end else if (clr_adv) begin
                clr_col <= clr_col + 1'b1;
            end
        end
    end
`else
    // Without the clear, a scroll is just a pointer bump; the recycled row keeps stale data.
    always_comb begin
        scroll_ready = 1'b1;
        busy         = 1'b0;
        char_ready   = slot_free && !scroll_valid;
        top_adv      = scroll_valid;
        load_en      = char_valid && char_ready;
        load_row     = char_phys_row;
        load_col     = char_col;
        load_byte    = char_byte;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            top_row     <= '0;
            write_valid <= 1'b0;
            write_row   <= '0;
            write_col   <= '0;
            write_byte  <= '0;
        end else begin
            if (top_adv) begin
                top_row <= top_row_next;
            end
            if (load_en) begin
                write_valid <= 1'b1;
                write_row   <= load_row;
                write_col   <= load_col;
                write_byte  <= load_byte;
            end else if (write_ready) begin
                write_valid <= 1'b0;
            end
        end
    end

    char_in_range: assert property (@(posedge clk) disable iff (reset)
        char_valid |-> (({1'b0, char_row} < ROWS_EXT) && ({1'b0, char_col} < COLS_EXT)));

endmodule

// File: tb/tb_vram_scroll_arbiter.sv
// Scoreboard bench for vram_scroll_arbiter; covers both VRAM_SCROLL_CLEAR_EN builds.
module tb_vram_scroll_arbiter;

    localparam int ROWS  = 30;
    localparam int COLS  = 80;
    localparam int ROW_W = 5;
    localparam int COL_W = 7;

    logic             clk = 1'b0;
    logic             reset;
    logic             char_valid;
    logic             char_ready;
    logic [ROW_W-1:0] char_row;
    logic [COL_W-1:0] char_col;
    logic [7:0]       char_byte;
    logic             scroll_valid;
    logic             scroll_ready;
    logic             busy;
    logic [ROW_W-1:0] top_row;
    logic             write_valid;
    logic             write_ready;
    logic [ROW_W-1:0] write_row;
    logic [COL_W-1:0] write_col;
    logic [7:0]       write_byte;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [7:0]       b;
    } wr_t;

    wr_t              exp_q[$];
    int               n_checks = 0;
    int               n_pass = 0;
    int               writes_seen = 0;
    logic [ROW_W-1:0] model_top = '0;

    vram_scroll_arbiter #(
        .ROWS (ROWS),
        .COLS (COLS),
        .ROW_W(ROW_W),
        .COL_W(COL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .char_row    (char_row),
        .char_col    (char_col),
        .char_byte   (char_byte),
        .scroll_valid(scroll_valid),
        .scroll_ready(scroll_ready),
        .busy        (busy),
        .top_row     (top_row),
        .write_valid (write_valid),
        .write_ready (write_ready),
        .write_row   (write_row),
        .write_col   (write_col),
        .write_byte  (write_byte)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [ROW_W-1:0] phys(input logic [ROW_W-1:0] top, input logic [ROW_W-1:0] r);
        int s;
        s = int'(top) + int'(r);
        if (s >= ROWS) s = s - ROWS;
        return ROW_W'(s);
    endfunction

    // Handshakes seen at negedge complete on the following posedge.
    always @(negedge clk) begin
        if (!reset) begin
            if (char_valid && char_ready)
                exp_q.push_back({phys(model_top, char_row), char_col, char_byte});
            if (scroll_valid && scroll_ready) begin
`ifdef VRAM_SCROLL_CLEAR_EN
                for (int c = 0; c < COLS; c++)
                    exp_q.push_back({model_top, COL_W'(c), 8'h20});
`endif
                model_top = phys(model_top, ROW_W'(1));
            end
        end
        if (write_valid && write_ready) begin
            wr_t e;
            writes_seen++;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got row=%0d col=%0d byte=%h, required no write",
                         write_row, write_col, write_byte);
            end else begin
                e = exp_q.pop_front();
                if ({write_row, write_col, write_byte} !== e)
                    $display("FAIL write_data: got row=%0d col=%0d byte=%h, required row=%0d col=%0d byte=%h",
                             write_row, write_col, write_byte, e.row, e.col, e.b);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset        = 1'b1;
        char_valid   = 1'b0;
        scroll_valid = 1'b0;
        write_ready  = 1'b1;
        char_row     = '0;
        char_col     = '0;
        char_byte    = '0;
        tick;
        tick;
        reset = 1'b0;
        exp_q.delete();
        model_top = '0;
    endtask

    task automatic send_char(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c, input logic [7:0] b);
        bit ok = 0;
        tick;
        char_valid = 1'b1;
        char_row   = r;
        char_col   = c;
        char_byte  = b;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (char_ready) begin
                ok = 1;
                break;
            end
        end
        tick;
        char_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL char_accept: got no char_ready within 400 cycles, required accept");
        else n_pass++;
    endtask

    task automatic send_scroll;
        bit ok = 0;
        tick;
        scroll_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (scroll_ready) begin
                ok = 1;
                break;
            end
        end
        tick;
        scroll_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL scroll_accept: got no scroll_ready within 400 cycles, required accept");
        else n_pass++;
    endtask

    task automatic wait_idle;
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL idle_wait: got busy=%b after 400 cycles, required 0", busy);
        else n_pass++;
    endtask

    task automatic wait_drain;
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL drain: got %0d writes outstanding, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        n_checks++;
        if (write_valid !== 1'b0) $display("FAIL reset_write_valid: got %b, required 0", write_valid);
        else n_pass++;
        n_checks++;
        if (top_row !== '0) $display("FAIL reset_top_row: got %0d, required 0", top_row);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy);
        else n_pass++;
        n_checks++;
        if ({write_row, write_col, write_byte} !== '0)
            $display("FAIL reset_write_data: got row=%0d col=%0d byte=%h, required zeros", write_row, write_col, write_byte);
        else n_pass++;
        n_checks++;
        if (char_ready !== 1'b1 || scroll_ready !== 1'b1)
            $display("FAIL reset_ready: got char_ready=%b scroll_ready=%b, required 1/1", char_ready, scroll_ready);
        else n_pass++;
    endtask

    task automatic test_single_char;
        write_ready = 1'b1;
        send_char(5'd3, 7'd5, 8'h41);
        @(negedge clk);
        n_checks++;
        if (write_valid !== 1'b1 || write_row !== 5'd3 || write_col !== 7'd5 || write_byte !== 8'h41)
            $display("FAIL char_latency: got v=%b row=%0d col=%0d byte=%h, required v=1 row=3 col=5 byte=41",
                     write_valid, write_row, write_col, write_byte);
        else n_pass++;
        n_checks++;
        if (top_row !== 5'd0) $display("FAIL char_top_row: got %0d, required 0", top_row);
        else n_pass++;
        wait_drain;
    endtask

    task automatic test_back_to_back;
        bit stable_ok = 1;
        bit thr_ok = 1;
        tick;
        write_ready = 1'b0;
        char_valid  = 1'b1;
        char_row    = 5'd1;
        char_col    = 7'd10;
        char_byte   = 8'h50;
        @(negedge clk);
        n_checks++;
        if (char_ready !== 1'b1) $display("FAIL b2b_first_ready: got %b, required 1", char_ready);
        else n_pass++;
        tick;
        char_row  = 5'd2;
        char_col  = 7'd11;
        char_byte = 8'h51;
        repeat (4) begin
            @(negedge clk);
            if (char_ready !== 1'b0 || write_valid !== 1'b1 || write_row !== 5'd1 ||
                write_col !== 7'd10 || write_byte !== 8'h50)
                stable_ok = 0;
            tick;
        end
        n_checks++;
        if (!stable_ok)
            $display("FAIL b2b_stall_hold: got unstable output or char_ready during stall, required held row=1 col=10 byte=50");
        else n_pass++;
        write_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (char_ready !== 1'b1) $display("FAIL b2b_release_ready: got %b, required 1", char_ready);
        else n_pass++;
        tick;
        for (int i = 0; i < 6; i++) begin
            char_row  = ROW_W'(i + 20);
            char_col  = COL_W'(70 + i);
            char_byte = 8'h60 + 8'(i);
            @(negedge clk);
            if (char_ready !== 1'b1) thr_ok = 0;
            tick;
        end
        char_valid = 1'b0;
        n_checks++;
        if (!thr_ok) $display("FAIL b2b_throughput: got char_ready low in burst, required 1 every cycle");
        else n_pass++;
        wait_drain;
    endtask

`ifdef VRAM_SCROLL_CLEAR_EN
    task automatic test_scroll_clear;
        int  w0;
        int  cyc = 0;
        bit  ready_ok = 1;
        do_reset;
        w0 = writes_seen;
        send_scroll;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            if (char_ready !== 1'b0 || scroll_ready !== 1'b0) ready_ok = 0;
            cyc++;
        end
        n_checks++;
        if (cyc != COLS) $display("FAIL clear_cycles: got %0d busy cycles, required %0d", cyc, COLS);
        else n_pass++;
        n_checks++;
        if (!ready_ok) $display("FAIL clear_ready: got ready high during clear, required 0");
        else n_pass++;
        n_checks++;
        if (top_row !== 5'd1) $display("FAIL clear_top_row: got %0d, required 1", top_row);
        else n_pass++;
        wait_drain;
        n_checks++;
        if (writes_seen - w0 != COLS) $display("FAIL clear_write_count: got %0d, required %0d", writes_seen - w0, COLS);
        else n_pass++;
    endtask

    task automatic test_reset_mid_clear;
        bit found = 0;
        do_reset;
        send_scroll;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (write_valid === 1'b1 && write_col === 7'd40) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (!found) $display("FAIL midclr_reach: got no write at col 40, required one");
        else n_pass++;
        reset = 1'b1;
        tick;
        n_checks++;
        if (write_valid !== 1'b0 || top_row !== 5'd0 || busy !== 1'b0)
            $display("FAIL midclr_reset: got v=%b top=%0d busy=%b, required 0/0/0", write_valid, top_row, busy);
        else n_pass++;
        reset = 1'b0;
        exp_q.delete();
        model_top = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (write_valid !== 1'b0 || busy !== 1'b0 || char_ready !== 1'b1)
            $display("FAIL midclr_idle: got v=%b busy=%b char_ready=%b, required 0/0/1", write_valid, busy, char_ready);
        else n_pass++;
    endtask
`else
    task automatic test_scroll_noclear;
        int w0;
        do_reset;
        w0 = writes_seen;
        scroll_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (scroll_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL noclr_ready: got scroll_ready=%b busy=%b, required 1/0", scroll_ready, busy);
        else n_pass++;
        tick;
        scroll_valid = 1'b0;
        n_checks++;
        if (top_row !== 5'd1) $display("FAIL noclr_top_row: got %0d, required 1", top_row);
        else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if (writes_seen != w0 || write_valid !== 1'b0)
            $display("FAIL noclr_no_writes: got %0d writes v=%b, required 0 writes", writes_seen - w0, write_valid);
        else n_pass++;
    endtask
`endif

    task automatic test_wrap;
        do_reset;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    tick;
                    write_ready = 1'($urandom_range(0, 1));
                end
                write_ready = 1'b1;
            end
            send_scroll;
        join
        wait_drain;
        for (int i = 1; i < 29; i++) send_scroll;
        wait_idle;
        n_checks++;
        if (top_row !== 5'd29) $display("FAIL wrap_top_29: got %0d, required 29", top_row);
        else n_pass++;
        send_char(5'd2, 7'd9, 8'h43);
        @(negedge clk);
        n_checks++;
        if (write_valid !== 1'b1 || write_row !== 5'd1 || write_col !== 7'd9)
            $display("FAIL wrap_char_row: got v=%b row=%0d col=%0d, required v=1 row=1 col=9", write_valid, write_row, write_col);
        else n_pass++;
        wait_drain;
        send_scroll;
        wait_idle;
        n_checks++;
        if (top_row !== 5'd0) $display("FAIL wrap_top_0: got %0d, required 0", top_row);
        else n_pass++;
        wait_drain;
    endtask

    task automatic test_simultaneous;
        bit ok = 0;
        do_reset;
        char_valid   = 1'b1;
        char_row     = 5'd4;
        char_col     = 7'd7;
        char_byte    = 8'h42;
        scroll_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (scroll_ready !== 1'b1 || char_ready !== 1'b0)
            $display("FAIL simul_priority: got scroll_ready=%b char_ready=%b, required 1/0", scroll_ready, char_ready);
        else n_pass++;
        tick;
        scroll_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (char_ready) begin
                ok = 1;
                break;
            end
        end
        tick;
        char_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL simul_char_accept: got no char_ready, required accept after scroll");
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (write_valid !== 1'b1 || write_row !== 5'd5 || write_byte !== 8'h42)
            $display("FAIL simul_char_row: got v=%b row=%0d byte=%h, required v=1 row=5 byte=42", write_valid, write_row, write_byte);
        else n_pass++;
        wait_drain;
    endtask

    initial begin
        test_reset;
        test_single_char;
        test_back_to_back;
`ifdef VRAM_SCROLL_CLEAR_EN
        test_scroll_clear;
`else
        test_scroll_noclear;
`endif
        test_wrap;
        test_simultaneous;
`ifdef VRAM_SCROLL_CLEAR_EN
        test_reset_mid_clear;
`endif
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL final_queue: got %0d writes outstanding, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
